// File: rtl/compression_pkg.sv
// ---------------------------------------------------------------------------
// compression_pkg
//
// Shared definitions for the compression dictionaries and their boot-time
// loader: default field widths, dictionary sizes, the default memory-image
// base address, the loader state encoding and a small width helper.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package compression_pkg;

  // Default value/key widths of the three dictionaries.
  localparam int DEF_FIELD1_VAL_WIDTH = 7;
  localparam int DEF_FIELD2_VAL_WIDTH = 10;
  localparam int DEF_FIELD3_VAL_WIDTH = 15;
  localparam int DEF_FIELD1_KEY_WIDTH = 3;
  localparam int DEF_FIELD2_KEY_WIDTH = 5;
  localparam int DEF_FIELD3_KEY_WIDTH = 8;

  // Entry counts for the default key widths.
  localparam int N1   = 1 << DEF_FIELD1_KEY_WIDTH;
  localparam int N2   = 1 << DEF_FIELD2_KEY_WIDTH;
  localparam int N3   = 1 << DEF_FIELD3_KEY_WIDTH;
  localparam int NTOT = N1 + N2 + N3;

  // Word-aligned byte address of the dictionary image.
  localparam logic [31:0] DEF_DICT_BASE_ADDR = 32'h0001_0000;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PORTWAIT = 3'd1,
    ST_FETCH    = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DONE     = 3'd4
  } loader_state_t;

  // Largest of three widths; sizes the capture register so that every
  // dictionary can take its value slice from the same word.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mem_port_arb.sv
// ---------------------------------------------------------------------------
// mem_port_arb
//
// 2:1 combinational mux for the single memory port. When loader_owns is set
// the loader drives the port and the fetch controller sees ready=0, which
// stalls (but never drops) its request. Otherwise the controller's request
// passes straight through. Read data always fans out to the controller.
//
// Ports:
//   loader_owns   in   1   loader currently owns the port
//   loader_valid  in   1   loader request
//   loader_addr   in   32  loader address
//   ctrl_valid    in   1   fetch-controller request
//   ctrl_addr     in   32  fetch-controller address
//   ctrl_ready    out  1   ready back to the controller
//   ctrl_rdata    out  32  read data back to the controller
//   mem_valid     out  1   request to memory
//   mem_addr      out  32  address to memory
//   mem_ready     in   1   memory ready (rdata valid this cycle)
//   mem_rdata     in   32  memory read data
// ---------------------------------------------------------------------------
module mem_port_arb (
  input  logic        loader_owns,
  input  logic        loader_valid,
  input  logic [31:0] loader_addr,
  input  logic        ctrl_valid,
  input  logic [31:0] ctrl_addr,
  output logic        ctrl_ready,
  output logic [31:0] ctrl_rdata,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  assign mem_valid  = loader_owns ? loader_valid : ctrl_valid;
  assign mem_addr   = loader_owns ? loader_addr  : ctrl_addr;
  assign ctrl_ready = loader_owns ? 1'b0         : mem_ready;
  assign ctrl_rdata = mem_rdata;

endmodule

// File: rtl/dict_loader.sv
// ---------------------------------------------------------------------------
// dict_loader
//
// Boot-time sequencer that fetches the three compression dictionaries from a
// memory image (one 32-bit word per entry, key order, dict1 then dict2 then
// dict3) and writes them through the dictionaries' write ports. It owns the
// memory port only while fetching/writing; otherwise the fetch controller's
// traffic passes straight through. proc_stall holds the core off until done.
//
// Optional feature (macro DICT_LOADER_CHECKSUM_EN): one extra word after the
// image must equal the XOR of all image words; a mismatch raises chk_err.
//
// Ports:
//   clk                 in   1   clock
//   resetn              in   1   asynchronous active-low reset
//   start               in   1   1-cycle pulse, (re)starts a load
//   busy                out  1   load in progress
//   done                out  1   sticky, all entries written
//   proc_stall          out  1   busy or start pending
//   ctrl_mem_req_valid  in   1   fetch-controller request
//   ctrl_mem_req_ready  out  1   ready back to the controller
//   ctrl_mem_req_addr   in   32  controller address
//   ctrl_mem_req_rdata  out  32  read data to the controller
//   mem_req_valid       out  1   request to memory
//   mem_req_ready       in   1   memory ready (rdata valid this cycle)
//   mem_req_addr        out  32  memory address
//   mem_req_rdata       in   32  memory read data
//   dictN_write_enable  out  1   N=1..3, one pulse per entry
//   dictN_write_val     out  FIELDN_VAL_WIDTH  captured word low bits
//   chk_err             out  1   checksum mismatch (DICT_LOADER_CHECKSUM_EN)
// ---------------------------------------------------------------------------
module dict_loader #(
  parameter int          FIELD1_VAL_WIDTH = compression_pkg::DEF_FIELD1_VAL_WIDTH,
  parameter int          FIELD2_VAL_WIDTH = compression_pkg::DEF_FIELD2_VAL_WIDTH,
  parameter int          FIELD3_VAL_WIDTH = compression_pkg::DEF_FIELD3_VAL_WIDTH,
  parameter int          FIELD1_KEY_WIDTH = compression_pkg::DEF_FIELD1_KEY_WIDTH,
  parameter int          FIELD2_KEY_WIDTH = compression_pkg::DEF_FIELD2_KEY_WIDTH,
  parameter int          FIELD3_KEY_WIDTH = compression_pkg::DEF_FIELD3_KEY_WIDTH,
  parameter logic [31:0] DICT_BASE_ADDR   = compression_pkg::DEF_DICT_BASE_ADDR,
  parameter bit          AUTO_START       = 1'b1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        proc_stall,
  input  logic                        ctrl_mem_req_valid,
  output logic                        ctrl_mem_req_ready,
  input  logic [31:0]                 ctrl_mem_req_addr,
  output logic [31:0]                 ctrl_mem_req_rdata,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [31:0]                 mem_req_addr,
  input  logic [31:0]                 mem_req_rdata,
  output logic                        dict1_write_enable,
  output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  output logic                        dict2_write_enable,
  output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  output logic                        dict3_write_enable,
  output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val
`ifdef DICT_LOADER_CHECKSUM_EN
  ,
  output logic                        chk_err
`endif
);

  import compression_pkg::*;

  localparam int NUM1    = 1 << FIELD1_KEY_WIDTH;
  localparam int NUM2    = 1 << FIELD2_KEY_WIDTH;
  localparam int NUM3    = 1 << FIELD3_KEY_WIDTH;
  localparam int NUM_TOT = NUM1 + NUM2 + NUM3;
  // One extra count value so idx can reach NUM_TOT without wrapping.
  localparam int IDX_W   = $clog2(NUM_TOT + 1);
  localparam int WORD_W  = max3(FIELD1_VAL_WIDTH, FIELD2_VAL_WIDTH, FIELD3_VAL_WIDTH);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TOT - 1);
  localparam logic [IDX_W-1:0] IDX_B12  = IDX_W'(NUM1);
  localparam logic [IDX_W-1:0] IDX_B23  = IDX_W'(NUM1 + NUM2);
`ifdef DICT_LOADER_CHECKSUM_EN
  localparam logic [IDX_W-1:0] IDX_CHK  = IDX_W'(NUM_TOT);
`endif

  loader_state_t     state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [WORD_W-1:0] word_reg, word_next;
  logic              done_reg, done_next;
  logic              busy_reg, busy_next;
`ifdef DICT_LOADER_CHECKSUM_EN
  logic [31:0]       acc_reg, acc_next;
  logic              chk_err_reg, chk_err_next;
`endif

  logic              loader_valid;
  logic              loader_owns;
  logic              in_busy_state;
  logic              start_ok;
  logic [2:0]        dict_we;
  logic [31:0]       loader_addr;

  // start is only honoured while no load is running.
  assign start_ok      = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign in_busy_state = (state_reg == ST_PORTWAIT) || (state_reg == ST_FETCH) ||
                         (state_reg == ST_WRITE);
  assign loader_owns   = (state_reg == ST_FETCH) || (state_reg == ST_WRITE);
  assign loader_addr   = DICT_BASE_ADDR + (32'(idx_reg) << 2);

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= AUTO_START ? ST_PORTWAIT : ST_IDLE;
      idx_reg     <= '0;
      word_reg    <= '0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
`ifdef DICT_LOADER_CHECKSUM_EN
      acc_reg     <= '0;
      chk_err_reg <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      word_reg    <= word_next;
      done_reg    <= done_next;
      busy_reg    <= busy_next;
`ifdef DICT_LOADER_CHECKSUM_EN
      acc_reg     <= acc_next;
      chk_err_reg <= chk_err_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    word_next    = word_reg;
    done_next    = done_reg;
    loader_valid = 1'b0;
`ifdef DICT_LOADER_CHECKSUM_EN
    acc_next     = acc_reg;
    chk_err_next = chk_err_reg;
`endif

    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next = ST_PORTWAIT;
          idx_next   = '0;
          done_next  = 1'b0;
`ifdef DICT_LOADER_CHECKSUM_EN
          acc_next     = '0;
          chk_err_next = 1'b0;
`endif
        end
      end

      // Let any in-flight controller miss finish before taking the port.
      ST_PORTWAIT: begin
        if (!ctrl_mem_req_valid) begin
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        loader_valid = 1'b1;
        if (mem_req_ready) begin
`ifdef DICT_LOADER_CHECKSUM_EN
          if (idx_reg == IDX_CHK) begin
            // Trailing check word: compared, never written to a dictionary.
            chk_err_next = (mem_req_rdata != acc_reg);
            done_next    = 1'b1;
            state_next   = ST_DONE;
          end else begin
            word_next  = mem_req_rdata[WORD_W-1:0];
            acc_next   = acc_reg ^ mem_req_rdata;
            state_next = ST_WRITE;
          end
`else
          word_next  = mem_req_rdata[WORD_W-1:0];
          state_next = ST_WRITE;
`endif
        end
      end

      ST_WRITE: begin
        idx_next = idx_reg + IDX_W'(1);
        if (idx_reg == IDX_LAST) begin
`ifdef DICT_LOADER_CHECKSUM_EN
          state_next = ST_FETCH;
`else
          state_next = ST_DONE;
          done_next  = 1'b1;
`endif
        end else begin
          state_next = ST_FETCH;
        end
      end

      default: state_next = ST_IDLE;
    endcase

    // busy is registered alongside the state so it reads 0 in reset.
    busy_next = (state_next == ST_PORTWAIT) || (state_next == ST_FETCH) ||
                (state_next == ST_WRITE);
  end

  // -------------------------------------------------------------------------
  // Dictionary write strobes: entries fill in key order, dict1 first.
  // -------------------------------------------------------------------------
  always_comb begin
    dict_we = 3'b000;
    if (state_reg == ST_WRITE) begin
      if (idx_reg < IDX_B12) begin
        dict_we[0] = 1'b1;
      end else if (idx_reg < IDX_B23) begin
        dict_we[1] = 1'b1;
      end else begin
        dict_we[2] = 1'b1;
      end
    end
  end

  assign dict1_write_enable = dict_we[0];
  assign dict2_write_enable = dict_we[1];
  assign dict3_write_enable = dict_we[2];
  assign dict1_write_val    = word_reg[FIELD1_VAL_WIDTH-1:0];
  assign dict2_write_val    = word_reg[FIELD2_VAL_WIDTH-1:0];
  assign dict3_write_val    = word_reg[FIELD3_VAL_WIDTH-1:0];

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign proc_stall = in_busy_state || start_ok;
`ifdef DICT_LOADER_CHECKSUM_EN
  assign chk_err    = chk_err_reg;
`endif

  // -------------------------------------------------------------------------
  // Memory port mux
  // -------------------------------------------------------------------------
  mem_port_arb u_arb (
    .loader_owns  (loader_owns),
    .loader_valid (loader_valid),
    .loader_addr  (loader_addr),
    .ctrl_valid   (ctrl_mem_req_valid),
    .ctrl_addr    (ctrl_mem_req_addr),
    .ctrl_ready   (ctrl_mem_req_ready),
    .ctrl_rdata   (ctrl_mem_req_rdata),
    .mem_valid    (mem_req_valid),
    .mem_addr     (mem_req_addr),
    .mem_ready    (mem_req_ready),
    .mem_rdata    (mem_req_rdata)
  );

endmodule

// File: tb/tb_dict_loader.sv
// ---------------------------------------------------------------------------
// tb_dict_loader
//
// Directed bench for dict_loader. Memory image word i = PAT | i, so every
// dictionary value equals its entry number. A behavioural memory returns
// ready after a programmable number of request cycles.
// ---------------------------------------------------------------------------
module tb_dict_loader;
  import compression_pkg::*;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] PAT  = 32'h5A00_0000;
`ifdef DICT_LOADER_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, proc_stall;
  logic        ctrl_mem_req_valid = 1'b0;
  logic        ctrl_mem_req_ready;
  logic [31:0] ctrl_mem_req_addr = 32'h0;
  logic [31:0] ctrl_mem_req_rdata;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr, mem_req_rdata;
  logic        dict1_write_enable, dict2_write_enable, dict3_write_enable;
  logic [6:0]  dict1_write_val;
  logic [9:0]  dict2_write_val;
  logic [14:0] dict3_write_val;
`ifdef DICT_LOADER_CHECKSUM_EN
  logic        chk_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dict_loader dut (
    .clk                (clk),
    .resetn             (resetn),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .proc_stall         (proc_stall),
    .ctrl_mem_req_valid (ctrl_mem_req_valid),
    .ctrl_mem_req_ready (ctrl_mem_req_ready),
    .ctrl_mem_req_addr  (ctrl_mem_req_addr),
    .ctrl_mem_req_rdata (ctrl_mem_req_rdata),
    .mem_req_valid      (mem_req_valid),
    .mem_req_ready      (mem_req_ready),
    .mem_req_addr       (mem_req_addr),
    .mem_req_rdata      (mem_req_rdata),
    .dict1_write_enable (dict1_write_enable),
    .dict1_write_val    (dict1_write_val),
    .dict2_write_enable (dict2_write_enable),
    .dict2_write_val    (dict2_write_val),
    .dict3_write_enable (dict3_write_enable),
    .dict3_write_val    (dict3_write_val)
`ifdef DICT_LOADER_CHECKSUM_EN
    ,
    .chk_err            (chk_err)
`endif
  );

  // ---------------- memory model ----------------
  int          lat = 1;
  int          wait_cnt = 0;
  logic [31:0] chk_word = 32'h0;  // XOR of PAT|i over 296 words is 0

  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] cw);
    logic [31:0] off;
    off = a - BASE;
    if (a >= BASE && off < 32'(4 * NTOT)) return PAT | (off >> 2);
    if (a == BASE + 32'(4 * NTOT)) return cw;
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  assign mem_req_ready = mem_req_valid && (wait_cnt >= lat - 1);
  assign mem_req_rdata = mem_word(mem_req_addr, chk_word);

  always @(posedge clk) begin
    if (mem_req_valid && !mem_req_ready) wait_cnt <= wait_cnt + 1;
    else                                 wait_cnt <= 0;
  end

  // ---------------- write-port monitor ----------------
  int          k = 0, c1 = 0, c2 = 0, c3 = 0, bad = 0, hold_bad = 0;
  logic [14:0] last3 = '0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    logic [31:0] ev;
    if (!resetn) begin
      k = 0; c1 = 0; c2 = 0; c3 = 0; prev_wait = 1'b0;
    end else begin
      ev = PAT | 32'(k);
      if (int'(dict1_write_enable) + int'(dict2_write_enable) + int'(dict3_write_enable) > 1) begin
        bad++;
      end else if (dict1_write_enable) begin
        if (k >= 8 || dict1_write_val !== ev[6:0]) bad++;
        c1++; k++;
      end else if (dict2_write_enable) begin
        if (k < 8 || k >= 40 || dict2_write_val !== ev[9:0]) bad++;
        c2++; k++;
      end else if (dict3_write_enable) begin
        if (k < 40 || k >= 296 || dict3_write_val !== ev[14:0]) bad++;
        last3 = dict3_write_val;
        c3++; k++;
      end
      // A request still waiting must keep valid high and its address stable.
      if (prev_wait && !(mem_req_valid && mem_req_addr == prev_addr)) hold_bad++;
      prev_wait = mem_req_valid && !mem_req_ready;
      prev_addr = mem_req_addr;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    k = 0; c1 = 0; c2 = 0; c3 = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_first_fetch(input string tag);
    int n;
    n = 0;
    while (!(mem_req_valid && !ctrl_mem_req_valid) && n < 50) begin
      @(negedge clk); n++;
    end
    check({tag, "_fetch_seen"}, 32'(mem_req_valid), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk); n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_load(input string tag);
    check({tag, "_n_dict1"}, 32'(c1), 32'd8);
    check({tag, "_n_dict2"}, 32'(c2), 32'd32);
    check({tag, "_n_dict3"}, 32'(c3), 32'd256);
    check({tag, "_bad_writes"}, 32'(bad), 32'd0);
    check({tag, "_hold_bad"}, 32'(hold_bad), 32'd0);
    check({tag, "_last_dict3"}, 32'(last3), 32'd295);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_stall_after"}, 32'(proc_stall), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int cnt_ready;

    // Test 1: reset state, then automatic load with single-cycle memory.
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_stall", 32'(proc_stall), 32'd1);
    check("rst_we", {29'd0, dict1_write_enable, dict2_write_enable, dict3_write_enable}, 32'd0);
    check("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    resetn = 1'b1;
    wait_first_fetch("t1");
    check("t1_first_addr", mem_req_addr, BASE);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ctrl_ready", 32'(ctrl_mem_req_ready), 32'd0);
    wait_done("t1", 3000, n);
    check("t1_cycles", 32'(n), 32'(592 + EXTRA));
    check_load("t1");
`ifdef DICT_LOADER_CHECKSUM_EN
    check("t1_chk_err", 32'(chk_err), 32'd0);
`endif

    // Test 2 + 5: ready on the third request cycle; start from DONE reloads,
    // a start pulse mid-load is ignored.
    lat = 3;
    pulse_start();
    check("t2_done_clr", 32'(done), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    wait_first_fetch("t2");
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      start = (n == 400);
      @(negedge clk); n++;
    end
    start = 1'b0;
    check("t2_done", 32'(done), 32'd1);
    check("t2_cycles", 32'(n), 32'(296 * 4 + 3 * EXTRA));
    check_load("t2");

    // Test 3: controller miss in flight when start fires.
    @(negedge clk);
    k = 0; c1 = 0; c2 = 0; c3 = 0;
    ctrl_mem_req_valid = 1'b1;
    ctrl_mem_req_addr  = 32'h0000_2000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_stall", 32'(proc_stall), 32'd1);
    check("t3_pass_addr", mem_req_addr, 32'h0000_2000);
    n = 0;
    while (ctrl_mem_req_ready !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    check("t3_ctrl_ready", 32'(ctrl_mem_req_ready), 32'd1);
    check("t3_ctrl_rdata", ctrl_mem_req_rdata, 32'hC0DE_2000);
    @(posedge clk); #1;
    ctrl_mem_req_valid = 1'b0;
    @(negedge clk);
    check("t3_portwait_idle", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    check("t3_load_addr", mem_req_addr, BASE);
    ctrl_mem_req_valid = 1'b1;
    ctrl_mem_req_addr  = 32'h0000_3000;
    cnt_ready = 0;
    for (int i = 0; i < 20; i++) begin
      if (ctrl_mem_req_ready) cnt_ready++;
      @(negedge clk);
    end
    check("t3_ctrl_blocked", 32'(cnt_ready), 32'd0);
    wait_done("t3", 3000, n);
    check_load("t3");
    n = 0;
    while (ctrl_mem_req_ready !== 1'b1 && n < 10) begin
      @(negedge clk); n++;
    end
    check("t3_ctrl_resume", ctrl_mem_req_rdata & {32{ctrl_mem_req_ready}}, 32'hC0DE_3000);
    @(posedge clk); #1;
    ctrl_mem_req_valid = 1'b0;

    // Test 4: asynchronous reset near idx 100, then automatic reload.
    lat = 1;
    pulse_start();
    n = 0;
    while (k < 100 && n < 1000) begin
      @(negedge clk); n++;
    end
    check("t4_reached_100", 32'(k >= 100), 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    check("t4_rst_we", {29'd0, dict1_write_enable, dict2_write_enable, dict3_write_enable}, 32'd0);
    check("t4_rst_val3", 32'(dict3_write_val), 32'd0);
    check("t4_rst_mem_valid", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    wait_first_fetch("t4");
    check("t4_first_addr", mem_req_addr, BASE);
    wait_done("t4", 3000, n);
    check("t4_cycles", 32'(n), 32'(592 + EXTRA));
    check_load("t4");

`ifdef DICT_LOADER_CHECKSUM_EN
    // Test 6: corrupted then correct check word.
    chk_word = 32'h0000_0001;
    pulse_start();
    wait_done("t6a", 3000, n);
    check("t6a_chk_err", 32'(chk_err), 32'd1);
    check("t6a_done", 32'(done), 32'd1);
    chk_word = 32'h0;
    pulse_start();
    check("t6b_chk_clr", 32'(chk_err), 32'd0);
    wait_done("t6b", 3000, n);
    check("t6b_chk_err", 32'(chk_err), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
